// File: rtl/dlbf_coeffs_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the coefficient stream reader.
package dlbf_coeffs_pkg;

   localparam int unsigned DefDataWidth      = 64;
   localparam int unsigned DefRamDepth       = 4096;
   localparam int unsigned DefRamReadLatency = 4;
   localparam int unsigned DefAddrWidth      = 16;
   localparam int unsigned DefBlockLen       = 256;

   typedef logic [1:0] state_t;
   localparam state_t StIdle  = 2'd0;
   localparam state_t StIssue = 2'd1;
   localparam state_t StDrain = 2'd2;

   // Bits needed to hold every value from 0 up to and including depth.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/dlbf_coeffs_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push into an empty FIFO is visible the same cycle.
module dlbf_coeffs_sync_fifo
   import dlbf_coeffs_pkg::*;
#(
   parameter int unsigned WIDTH = 65,
   parameter int unsigned DEPTH = 6,
   parameter int unsigned CNT_W = cnt_width(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int unsigned     PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PtrW-1:0] PtrMax = PtrW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             empty, wr_en, rd_en;

   assign empty   = (count_q == '0);
   assign valid_o = !empty || push_i;
   assign rdata_o = empty ? wdata_i : mem_q[rd_ptr_q];
   assign count_o = count_q;
   // Popping while empty consumes the bypassed push word, so it is never stored.
   assign wr_en   = push_i && !(empty && pop_i);
   assign rd_en   = pop_i && !empty;

   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + PtrW'(1);
         if (rd_en) rd_ptr_q <= (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + PtrW'(1);
         count_q <= count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
      end
   end

endmodule

// File: rtl/dlbf_coeffs_stream_reader.sv
// RAM port-B reader streaming coefficient words to AXI4-Stream with credit-based prefetch.
// Optional DLBF_COEFFS_LOOP_EN adds loop_en to replay the buffer without leaving ISSUE.
module dlbf_coeffs_stream_reader
   import dlbf_coeffs_pkg::*;
#(
   parameter int unsigned DATA_WIDTH       = DefDataWidth,
   parameter int unsigned RAM_DEPTH        = DefRamDepth,
   parameter int unsigned RAM_READ_LATENCY = DefRamReadLatency,
   parameter int unsigned ADDR_WIDTH       = DefAddrWidth,
   parameter int unsigned BLOCK_LEN        = DefBlockLen,
   parameter int unsigned FIFO_DEPTH       = RAM_READ_LATENCY + 2
) (
   input  logic                  m_axis_clk,
   input  logic                  m_axis_rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] num_words,
`ifdef DLBF_COEFFS_LOOP_EN
   input  logic                  loop_en,
`endif
   output logic                  busy,
   output logic                  done,
   output logic                  enb,
   output logic [ADDR_WIDTH-1:0] addrb,
   input  logic [DATA_WIDTH-1:0] doutb,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast
);

   localparam int unsigned           Lat      = RAM_READ_LATENCY;
   localparam int unsigned           CntW     = cnt_width(FIFO_DEPTH);
   localparam int unsigned           CredW    = cnt_width(FIFO_DEPTH + RAM_READ_LATENCY);
   localparam int unsigned           BlkW     = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
   localparam logic [ADDR_WIDTH-1:0] AddrMask = ADDR_WIDTH'(RAM_DEPTH - 1);
   localparam logic [BlkW-1:0]       BlkMax   = BlkW'(BLOCK_LEN - 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, num_q, rd_idx_q, rd_idx_d;
   logic [BlkW-1:0]       blk_q, blk_d;
   logic [Lat-1:0]        vld_q, tag_q;
   logic                  done_q, done_d;
   logic [CntW-1:0]       fifo_cnt;
   logic                  fifo_valid, pop, issue_last, rd_tag, final_beat, loop_act;
   logic [DATA_WIDTH:0]   fifo_rdata;
   logic [CredW-1:0]      inflight, credit;

`ifdef DLBF_COEFFS_LOOP_EN
   assign loop_act = loop_en;
`else
   assign loop_act = 1'b0;
`endif

   always_comb begin
      inflight = '0;
      for (int i = 0; i < int'(Lat); i++) inflight = inflight + CredW'(vld_q[i]);
   end

   // Outstanding words (in flight plus buffered) after this cycle's pop leaves.
   assign credit     = inflight + CredW'(fifo_cnt) - CredW'(pop);
   assign enb        = (state_q == StIssue) && (credit < CredW'(FIFO_DEPTH));
   assign addrb      = (base_q + rd_idx_q) & AddrMask;
   assign issue_last = (rd_idx_q == num_q - ADDR_WIDTH'(1));
   assign rd_tag     = issue_last || (blk_q == BlkMax);
   assign pop        = fifo_valid && m_axis_tready;
   assign final_beat = pop && (credit == '0);

   assign busy          = (state_q != StIdle);
   assign done          = done_q;
   assign m_axis_tvalid = fifo_valid;
   assign m_axis_tdata  = fifo_valid ? fifo_rdata[DATA_WIDTH-1:0] : '0;
   assign m_axis_tlast  = fifo_valid && fifo_rdata[DATA_WIDTH];

   always_comb begin
      state_d  = state_q;
      rd_idx_d = rd_idx_q;
      blk_d    = blk_q;
      done_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (num_words == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d  = StIssue;
                  rd_idx_d = '0;
                  blk_d    = '0;
               end
            end
         end
         StIssue: begin
            if (enb) begin
               rd_idx_d = rd_idx_q + ADDR_WIDTH'(1);
               blk_d    = (blk_q == BlkMax) ? '0 : blk_q + BlkW'(1);
               if (issue_last) begin
                  if (loop_act) begin
                     rd_idx_d = '0;
                     blk_d    = '0;
                  end else begin
                     state_d = StDrain;
                  end
               end
            end
         end
         StDrain: begin
            if (final_beat) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge m_axis_clk or negedge m_axis_rst_n) begin
      if (!m_axis_rst_n) begin
         state_q  <= StIdle;
         base_q   <= '0;
         num_q    <= '0;
         rd_idx_q <= '0;
         blk_q    <= '0;
         vld_q    <= '0;
         tag_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rd_idx_q <= rd_idx_d;
         blk_q    <= blk_d;
         done_q   <= done_d;
         // The oldest stage lines up with doutb for the read issued Lat cycles ago.
         vld_q    <= (vld_q << 1) | Lat'(enb);
         tag_q    <= (tag_q << 1) | Lat'(enb && rd_tag);
         if ((state_q == StIdle) && start) begin
            base_q <= base_addr;
            num_q  <= num_words;
         end
      end
   end

   dlbf_coeffs_sync_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CntW)
   ) u_fifo (
      .clk_i   (m_axis_clk),
      .rst_ni  (m_axis_rst_n),
      .push_i  (vld_q[Lat-1]),
      .wdata_i ({tag_q[Lat-1], doutb}),
      .pop_i   (pop),
      .valid_o (fifo_valid),
      .rdata_o (fifo_rdata),
      .count_o (fifo_cnt)
   );

endmodule

// File: tb/tb_dlbf_coeffs_stream_reader.sv
// Directed table-driven bench for dlbf_coeffs_stream_reader with a latency-accurate RAM model.
module tb_dlbf_coeffs_stream_reader;

   localparam int unsigned DW    = 64;
   localparam int unsigned AW    = 16;
   localparam int unsigned Lat   = 4;
   localparam int unsigned Depth = 4096;
   localparam int unsigned FifoD = Lat + 2;
   localparam int          NV    = 6;

   typedef struct {
      int base;
      int num;
      int mode;       // 0: tready=1, 1: random tready, 2: tready=0 for cycles 0..20
      int poke;       // 1: pulse start with other parameters at cycle 3
      int exp_first;  // cycle of first tvalid (start cycle = 0), -1 none
      int exp_done;   // cycle of done pulse, -1 not checked
      int exp_lasts;  // tlast beats
      int exp_stall;  // enb pulses while tready held low, -1 not checked
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n, start, busy, done, enb, tvalid, tready, tlast;
   logic [AW-1:0] base_addr, num_words, addrb;
   logic [DW-1:0] doutb, tdata;
   logic [DW-1:0] ram [Depth];
   logic [AW-1:0] pa [Lat];
   vec_t          vecs [NV];
   vec_t          after_rst;
   int            n_checks = 0;
   int            n_fail = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      pa[0] <= addrb;
      for (int k = 1; k < int'(Lat); k++) pa[k] <= pa[k-1];
   end
   assign doutb = ram[pa[Lat-1][11:0]];

   dlbf_coeffs_stream_reader #(
      .DATA_WIDTH       (DW),
      .RAM_DEPTH        (Depth),
      .RAM_READ_LATENCY (Lat),
      .ADDR_WIDTH       (AW),
      .BLOCK_LEN        (256),
      .FIFO_DEPTH       (FifoD)
   ) dut (
      .m_axis_clk    (clk),
      .m_axis_rst_n  (rst_n),
      .start         (start),
      .base_addr     (base_addr),
      .num_words     (num_words),
`ifdef DLBF_COEFFS_LOOP_EN
      .loop_en       (1'b0),
`endif
      .busy          (busy),
      .done          (done),
      .enb           (enb),
      .addrb         (addrb),
      .doutb         (doutb),
      .m_axis_tdata  (tdata),
      .m_axis_tvalid (tvalid),
      .m_axis_tready (tready),
      .m_axis_tlast  (tlast)
   );

   function automatic logic [DW-1:0] word_at(input int a);
      return 64'hC0EF_0000_0000_0000 | DW'(a % Depth);
   endfunction

   function automatic logic ready_for(input int mode, input int cyc);
      if (mode == 1) return 1'($urandom_range(0, 1));
      if (mode == 2) return (cyc > 20);
      return 1'b1;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int            cyc, beats, issued, n_last, n_done, first_v, done_cyc, stall_enb, cred_err;
      int            post;
      bit            prev_stall, fin, exp_last;
      logic [DW-1:0] prev_data;
      logic          prev_last;
      cyc = 0; beats = 0; issued = 0; n_last = 0; n_done = 0; first_v = -1; done_cyc = -1;
      stall_enb = 0; cred_err = 0; post = 0; prev_stall = 0; fin = 0;
      prev_data = '0; prev_last = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; base_addr = AW'(v.base); num_words = AW'(v.num);
      tready = ready_for(v.mode, 0);
      while (!fin && cyc < 3000) begin
         @(negedge clk);
         if (prev_stall) begin
            check($sformatf("v%0d hold tvalid", id), 64'(tvalid), 64'd1);
            check($sformatf("v%0d hold tdata", id), tdata, prev_data);
            check($sformatf("v%0d hold tlast", id), 64'(tlast), 64'(prev_last));
         end
         if (tvalid && first_v < 0) first_v = cyc;
         if (enb) begin
            check($sformatf("v%0d addrb[%0d]", id, issued), 64'(addrb),
                  64'((v.base + issued) % Depth));
            if (issued - beats - int'(tvalid && tready) >= int'(FifoD)) cred_err++;
            if (v.mode == 2 && cyc <= 20) stall_enb++;
            issued++;
         end
         if (tvalid && tready) begin
            exp_last = (((beats + 1) % 256) == 0) || (beats == v.num - 1);
            check($sformatf("v%0d tdata[%0d]", id, beats), tdata, word_at(v.base + beats));
            check($sformatf("v%0d tlast[%0d]", id, beats), 64'(tlast), 64'(exp_last));
            if (tlast) n_last++;
            beats++;
         end
         if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
            check($sformatf("v%0d busy at done", id), 64'(busy), 64'd0);
         end
         prev_stall = tvalid && !tready;
         prev_data  = tdata;
         prev_last  = tlast;
         if (n_done > 0) begin
            post++;
            if (post > 3) fin = 1'b1;
         end
         if (!fin) begin
            @(posedge clk); #1;
            cyc++;
            start = (v.poke != 0) && (cyc == 3);
            if (start) begin
               base_addr = AW'(777);
               num_words = AW'(2);
            end
            tready = ready_for(v.mode, cyc);
         end
      end
      start = 1'b0;
      check($sformatf("v%0d finished in budget", id), 64'(fin), 64'd1);
      check($sformatf("v%0d beats", id), 64'(beats), 64'(v.num));
      check($sformatf("v%0d reads issued", id), 64'(issued), 64'(v.num));
      check($sformatf("v%0d done pulses", id), 64'(n_done), 64'd1);
      check($sformatf("v%0d tlast count", id), 64'(n_last), 64'(v.exp_lasts));
      check($sformatf("v%0d first tvalid cycle", id), 64'(first_v), 64'(v.exp_first));
      check($sformatf("v%0d credit overrun", id), 64'(cred_err), 64'd0);
      if (v.exp_done >= 0)
         check($sformatf("v%0d done cycle", id), 64'(done_cyc), 64'(v.exp_done));
      if (v.exp_stall >= 0)
         check($sformatf("v%0d enb during stall", id), 64'(stall_enb), 64'(v.exp_stall));
   endtask

   initial begin
      int beats, n_done, n_valid;
      rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; tready = 1'b0;
      for (int i = 0; i < int'(Depth); i++) ram[i] = word_at(i);

      vecs[0]   = '{0,    8,   0, 0, 5,  13, 1, -1};
      vecs[1]   = '{4094, 4,   0, 0, 5,  9,  1, -1};
      vecs[2]   = '{0,    600, 1, 0, 5,  -1, 3, -1};
      vecs[3]   = '{32,   16,  2, 0, 5,  -1, 1, 6};
      vecs[4]   = '{0,    0,   0, 0, -1, 1,  0, -1};
      vecs[5]   = '{200,  10,  0, 1, 5,  15, 1, -1};
      after_rst = '{50,   32,  0, 0, 5,  37, 1, -1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset enb", 64'(enb), 64'd0);
      check("reset addrb", 64'(addrb), 64'd0);
      check("reset tvalid", 64'(tvalid), 64'd0);
      check("reset tlast", 64'(tlast), 64'd0);
      check("reset tdata", tdata, 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

      // Abort a 32-word transfer after 5 beats have been accepted.
      @(posedge clk); #1;
      start = 1'b1; base_addr = AW'(50); num_words = AW'(32); tready = 1'b1;
      beats = 0;
      for (int c = 0; c < 200 && beats < 5; c++) begin
         @(negedge clk);
         if (tvalid && tready) beats++;
         @(posedge clk); #1;
         start = 1'b0;
      end
      check("abort reached beat 5", 64'(beats), 64'd5);
      check("abort pre tvalid", 64'(tvalid), 64'd1);
      check("abort pre busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort tvalid", 64'(tvalid), 64'd0);
      check("abort busy", 64'(busy), 64'd0);
      check("abort enb", 64'(enb), 64'd0);
      check("abort tdata", tdata, 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_done = 0; n_valid = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (done) n_done++;
         if (tvalid) n_valid++;
      end
      check("abort no done", 64'(n_done), 64'd0);
      check("abort no stale beats", 64'(n_valid), 64'd0);
      run_vec(after_rst, 9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
